// File: rtl/stack_arb_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : stack_arb_ctrl
//  Description : Sequencing and arbitration controller for an 8x4 stack memory.
//                Two requesters (A, B) issue push/pop requests. At most one
//                operation is granted per cycle, using round-robin between
//                eligible requesters. The block owns the top-of-stack pointer
//                and the full/empty state. It drives the memory's push/pop
//                enables and tags returning pop data with the requester ID.
//  Optional    : define STACK_ARB_CTRL_ERRCNT_EN to add err_cnt, a saturating
//                8-bit count of cycles with an overflow/underflow condition.
//  Ports       : clk, rst_n (sync, active-low)
//                a_push/a_pop/a_data, b_push/b_pop/b_data  - requests
//                a_gnt, b_gnt                               - grants (comb)
//                pushenbl, popenbl, pushdatain, tos         - memory drive
//                stack_full, stack_empty                    - registered status
//                rd_valid, rd_id                            - pop data tag
//                ovf_err, unf_err                           - sticky errors
//                err_cnt                                    - optional counter
//  Revision    : 1.0 - initial release
// ============================================================================
module stack_arb_ctrl #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int DW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_push,
    input  logic          a_pop,
    input  logic [DW-1:0] a_data,
    input  logic          b_push,
    input  logic          b_pop,
    input  logic [DW-1:0] b_data,
    output logic          a_gnt,
    output logic          b_gnt,
    output logic          pushenbl,
    output logic          popenbl,
    output logic [AW-1:0] tos,
    output logic          stack_full,
    output logic          stack_empty,
    output logic [DW-1:0] pushdatain,
    output logic          rd_valid,
    output logic          rd_id,
`ifdef STACK_ARB_CTRL_ERRCNT_EN
    output logic [7:0]    err_cnt,
`endif
    output logic          ovf_err,
    output logic          unf_err
);

    localparam logic [AW:0]   c_full_cnt = (AW+1)'(DEPTH);
    localparam logic [AW:0]   c_last_cnt = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0]   c_cnt_one  = (AW+1)'(1);
    localparam logic [AW-1:0] c_tos_one  = AW'(1);

    logic [AW-1:0] r_tos;
    logic [AW:0]   r_count;
    logic          r_full;
    logic          r_empty;
    logic          r_rr_b;      // 1: B wins the next contention cycle
    logic          r_rd_valid;
    logic          r_rd_id;
    logic          r_ovf;
    logic          r_unf;

    logic w_a_ill, w_b_ill;
    logic w_a_push, w_a_pop, w_b_push, w_b_pop;
    logic w_a_elig, w_b_elig;
    logic w_a_gnt, w_b_gnt;
    logic w_push, w_pop;
    logic w_ovf, w_unf;

    always_comb begin
        // Push and pop together from one requester is treated as no request.
        w_a_ill  = a_push & a_pop;
        w_b_ill  = b_push & b_pop;
        w_a_push = a_push & ~a_pop;
        w_a_pop  = a_pop  & ~a_push;
        w_b_push = b_push & ~b_pop;
        w_b_pop  = b_pop  & ~b_push;

        w_a_elig = (w_a_push & ~r_full) | (w_a_pop & ~r_empty);
        w_b_elig = (w_b_push & ~r_full) | (w_b_pop & ~r_empty);

        // A sole eligible requester wins. Under contention, the pointer decides.
        w_a_gnt  = w_a_elig & (~w_b_elig | ~r_rr_b);
        w_b_gnt  = w_b_elig & (~w_a_elig |  r_rr_b);

        w_push   = (w_a_gnt & w_a_push) | (w_b_gnt & w_b_push);
        w_pop    = (w_a_gnt & w_a_pop)  | (w_b_gnt & w_b_pop);

        // Ineligible requests flag an error even if the other side is granted.
        w_ovf    = w_a_ill | w_b_ill | ((w_a_push | w_b_push) & r_full);
        w_unf    = w_a_ill | w_b_ill | ((w_a_pop  | w_b_pop)  & r_empty);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tos      <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_rr_b     <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_id    <= 1'b0;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
        end else begin
            if (w_push) begin
                r_empty <= 1'b0;
                // The last push fills the top slot in place; tos stays at DEPTH-1.
                if (r_count == c_last_cnt) begin
                    r_count <= c_full_cnt;
                    r_full  <= 1'b1;
                end else begin
                    r_count <= r_count + c_cnt_one;
                    r_tos   <= r_tos + c_tos_one;
                end
            end else if (w_pop) begin
                // When the stack is full, the memory reads at tos itself, so tos holds.
                if (r_full) begin
                    r_count <= c_last_cnt;
                    r_full  <= 1'b0;
                end else begin
                    r_count <= r_count - c_cnt_one;
                    r_tos   <= r_tos - c_tos_one;
                    r_empty <= (r_count == c_cnt_one);
                end
            end

            if (w_a_gnt | w_b_gnt)
                r_rr_b <= w_a_gnt;

            r_rd_valid <= w_pop;
            if (w_pop)
                r_rd_id <= w_b_gnt;

            r_ovf <= r_ovf | w_ovf;
            r_unf <= r_unf | w_unf;
        end
    end

`ifdef STACK_ARB_CTRL_ERRCNT_EN
    logic [7:0] r_err_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_err_cnt <= 8'd0;
        else if ((w_ovf | w_unf) && (r_err_cnt != 8'hFF))
            r_err_cnt <= r_err_cnt + 8'd1;
    end

    assign err_cnt = r_err_cnt;
`endif

    assign a_gnt       = w_a_gnt;
    assign b_gnt       = w_b_gnt;
    assign pushenbl    = w_push;
    assign popenbl     = w_pop;
    assign pushdatain  = w_b_gnt ? b_data : a_data;
    assign tos         = r_tos;
    assign stack_full  = r_full;
    assign stack_empty = r_empty;
    assign rd_valid    = r_rd_valid;
    assign rd_id       = r_rd_id;
    assign ovf_err     = r_ovf;
    assign unf_err     = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_stack_arb_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stack_arb_ctrl
//  Description : Directed self-checking bench for stack_arb_ctrl. It includes
//                a behavioural 8x4 stack memory, so pop data can be checked.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stack_arb_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a_push, a_pop, b_push, b_pop;
    logic [3:0] a_data, b_data;
    logic       a_gnt, b_gnt, pushenbl, popenbl;
    logic [2:0] tos;
    logic       stack_full, stack_empty;
    logic [3:0] pushdatain;
    logic       rd_valid, rd_id, ovf_err, unf_err;
`ifdef STACK_ARB_CTRL_ERRCNT_EN
    logic [7:0] err_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    stack_arb_ctrl #(.DEPTH(8), .AW(3), .DW(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_push(a_push), .a_pop(a_pop), .a_data(a_data),
        .b_push(b_push), .b_pop(b_pop), .b_data(b_data),
        .a_gnt(a_gnt), .b_gnt(b_gnt),
        .pushenbl(pushenbl), .popenbl(popenbl), .tos(tos),
        .stack_full(stack_full), .stack_empty(stack_empty),
        .pushdatain(pushdatain), .rd_valid(rd_valid), .rd_id(rd_id),
`ifdef STACK_ARB_CTRL_ERRCNT_EN
        .err_cnt(err_cnt),
`endif
        .ovf_err(ovf_err), .unf_err(unf_err)
    );

    // Stack memory: write at tos, read at tos when full else at tos-1.
    logic [3:0] mem [0:7];
    logic [3:0] popdataout;
    always @(posedge clk) begin
        if (pushenbl) mem[tos] <= pushdatain;
        if (popenbl)  popdataout <= stack_full ? mem[tos] : mem[tos - 3'd1];
    end

    task automatic idle_inputs;
        a_push = 1'b0; a_pop = 1'b0; a_data = 4'h0;
        b_push = 1'b0; b_pop = 1'b0; b_data = 4'h0;
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        do_reset();
        #1;
        n_cmp++;
        if ({tos, stack_full, stack_empty} !== {3'd0, 1'b0, 1'b1}) begin
            n_bad++; $display("FAIL reset_state: got tos=%0d full=%b empty=%b want 0/0/1", tos, stack_full, stack_empty);
        end
        n_cmp++;
        if ({rd_valid, rd_id, ovf_err, unf_err} !== 4'b0000) begin
            n_bad++; $display("FAIL reset_flags: got %b want 0000", {rd_valid, rd_id, ovf_err, unf_err});
        end
        n_cmp++;
        if ({a_gnt, b_gnt, pushenbl, popenbl} !== 4'b0000) begin
            n_bad++; $display("FAIL reset_comb: got %b want 0000", {a_gnt, b_gnt, pushenbl, popenbl});
        end
`ifdef STACK_ARB_CTRL_ERRCNT_EN
        n_cmp++;
        if (err_cnt !== 8'd0) begin
            n_bad++; $display("FAIL reset_errcnt: got %0d want 0", err_cnt);
        end
`endif
    endtask

    task automatic test_push_fill;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            a_push = 1'b1; a_data = 4'(i + 1);
            #1;
            n_cmp++;
            if ({a_gnt, b_gnt, pushenbl, popenbl} !== 4'b1010) begin
                n_bad++; $display("FAIL fill_grant[%0d]: got %b want 1010", i, {a_gnt, b_gnt, pushenbl, popenbl});
            end
            n_cmp++;
            if (pushdatain !== 4'(i + 1)) begin
                n_bad++; $display("FAIL fill_data[%0d]: got %h want %h", i, pushdatain, 4'(i + 1));
            end
            n_cmp++;
            if ({tos, stack_full, stack_empty} !== {3'(i), 1'b0, (i == 0)}) begin
                n_bad++; $display("FAIL fill_state[%0d]: got tos=%0d full=%b empty=%b", i, tos, stack_full, stack_empty);
            end
        end
        @(negedge clk);
        a_push = 1'b0;
        #1;
        n_cmp++;
        if ({tos, stack_full, stack_empty} !== {3'd7, 1'b1, 1'b0}) begin
            n_bad++; $display("FAIL fill_end: got tos=%0d full=%b empty=%b want 7/1/0", tos, stack_full, stack_empty);
        end
    endtask

    task automatic test_pop_drain;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            b_pop = 1'b1;
            #1;
            n_cmp++;
            if ({a_gnt, b_gnt, pushenbl, popenbl} !== 4'b0101) begin
                n_bad++; $display("FAIL drain_grant[%0d]: got %b want 0101", i, {a_gnt, b_gnt, pushenbl, popenbl});
            end
            n_cmp++;
            if ({tos, stack_full} !== {3'((i <= 1) ? 7 : 8 - i), (i == 0)}) begin
                n_bad++; $display("FAIL drain_tos[%0d]: got tos=%0d full=%b", i, tos, stack_full);
            end
            if (i > 0) begin
                n_cmp++;
                if ({rd_valid, rd_id, popdataout} !== {2'b11, 4'(9 - i)}) begin
                    n_bad++; $display("FAIL drain_rd[%0d]: got v=%b id=%b d=%h want 1/1/%h", i, rd_valid, rd_id, popdataout, 4'(9 - i));
                end
            end
        end
        @(negedge clk);
        b_pop = 1'b0;
        #1;
        n_cmp++;
        if ({rd_valid, rd_id, popdataout, tos, stack_empty, stack_full} !== {2'b11, 4'h1, 3'd0, 1'b1, 1'b0}) begin
            n_bad++; $display("FAIL drain_end: got v=%b id=%b d=%h tos=%0d e=%b f=%b", rd_valid, rd_id, popdataout, tos, stack_empty, stack_full);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if ({rd_valid, ovf_err, unf_err} !== 3'b000) begin
            n_bad++; $display("FAIL drain_after: got v/ovf/unf=%b want 000", {rd_valid, ovf_err, unf_err});
        end
    endtask

    task automatic test_round_robin;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a_push = 1'b1; a_data = 4'h3; b_push = 1'b1; b_data = 4'h5;
            #1;
            n_cmp++;
            if ({a_gnt, b_gnt, pushdatain} !== ((i % 2 == 0) ? 6'b10_0011 : 6'b01_0101)) begin
                n_bad++; $display("FAIL rr_push[%0d]: got a=%b b=%b d=%h", i, a_gnt, b_gnt, pushdatain);
            end
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a_push = 1'b0; b_push = 1'b0; a_pop = 1'b1;
            #1;
            n_cmp++;
            if ({a_gnt, popenbl} !== 2'b11) begin
                n_bad++; $display("FAIL rr_sole_pop[%0d]: got a=%b pop=%b want 11", i, a_gnt, popenbl);
            end
            if (i > 0) begin
                n_cmp++;
                if ({rd_valid, rd_id, popdataout} !== {2'b10, (i % 2 == 1) ? 4'h5 : 4'h3}) begin
                    n_bad++; $display("FAIL rr_pop_data[%0d]: got v=%b id=%b d=%h", i, rd_valid, rd_id, popdataout);
                end
            end
        end
        @(negedge clk);
        a_pop = 1'b0;
        #1;
        n_cmp++;
        if ({rd_valid, rd_id, popdataout, stack_empty} !== {2'b10, 4'h3, 1'b1}) begin
            n_bad++; $display("FAIL rr_pop_last: got v=%b id=%b d=%h e=%b", rd_valid, rd_id, popdataout, stack_empty);
        end
    endtask

    task automatic test_underflow;
        do_reset();
        @(negedge clk);
        a_pop = 1'b1;
        #1;
        n_cmp++;
        if ({a_gnt, b_gnt, pushenbl, popenbl} !== 4'b0000) begin
            n_bad++; $display("FAIL unf_grant: got %b want 0000", {a_gnt, b_gnt, pushenbl, popenbl});
        end
        @(negedge clk);
        a_pop = 1'b0;
        #1;
        n_cmp++;
        if ({unf_err, ovf_err, rd_valid, stack_empty} !== 4'b1001) begin
            n_bad++; $display("FAIL unf_flag: got unf/ovf/v/e=%b want 1001", {unf_err, ovf_err, rd_valid, stack_empty});
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (unf_err !== 1'b1) begin
            n_bad++; $display("FAIL unf_sticky: got %b want 1", unf_err);
        end
`ifdef STACK_ARB_CTRL_ERRCNT_EN
        n_cmp++;
        if (err_cnt !== 8'd1) begin
            n_bad++; $display("FAIL unf_errcnt: got %0d want 1", err_cnt);
        end
`endif
    endtask

    task automatic test_full_contention;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            a_push = 1'b1; a_data = 4'(i + 6);
        end
        @(negedge clk);
        a_push = 1'b0; a_pop = 1'b1; b_push = 1'b1; b_data = 4'hF;
        #1;
        n_cmp++;
        if ({a_gnt, b_gnt, pushenbl, popenbl, stack_full} !== 5'b10011) begin
            n_bad++; $display("FAIL full_cont_grant: got %b want 10011", {a_gnt, b_gnt, pushenbl, popenbl, stack_full});
        end
        @(negedge clk);
        a_pop = 1'b0;
        #1;
        n_cmp++;
        if ({ovf_err, unf_err, stack_full, tos} !== {3'b100, 3'd7}) begin
            n_bad++; $display("FAIL full_cont_state: got ovf=%b unf=%b f=%b tos=%0d", ovf_err, unf_err, stack_full, tos);
        end
        n_cmp++;
        if ({rd_valid, rd_id, popdataout} !== {2'b10, 4'hD}) begin
            n_bad++; $display("FAIL full_cont_rd: got v=%b id=%b d=%h want 1/0/d", rd_valid, rd_id, popdataout);
        end
        n_cmp++;
        if ({b_gnt, pushenbl, pushdatain} !== {2'b11, 4'hF}) begin
            n_bad++; $display("FAIL full_cont_retry: got b=%b push=%b d=%h", b_gnt, pushenbl, pushdatain);
        end
        @(negedge clk);
        b_push = 1'b0;
        #1;
        n_cmp++;
        if ({stack_full, tos} !== {1'b1, 3'd7}) begin
            n_bad++; $display("FAIL full_refill: got f=%b tos=%0d want 1/7", stack_full, tos);
        end
`ifdef STACK_ARB_CTRL_ERRCNT_EN
        n_cmp++;
        if (err_cnt !== 8'd1) begin
            n_bad++; $display("FAIL full_errcnt: got %0d want 1", err_cnt);
        end
`endif
    endtask

    task automatic test_illegal;
        do_reset();
        @(negedge clk);
        a_push = 1'b1; a_pop = 1'b1; b_push = 1'b1; b_data = 4'h9;
        #1;
        n_cmp++;
        if ({a_gnt, b_gnt, pushenbl, popenbl, pushdatain} !== {4'b0110, 4'h9}) begin
            n_bad++; $display("FAIL illegal_grant: got %b d=%h want 0110 d=9", {a_gnt, b_gnt, pushenbl, popenbl}, pushdatain);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        n_cmp++;
        if ({ovf_err, unf_err, tos} !== {2'b11, 3'd1}) begin
            n_bad++; $display("FAIL illegal_flags: got ovf=%b unf=%b tos=%0d want 1/1/1", ovf_err, unf_err, tos);
        end
    endtask

    task automatic test_back_to_back;
        do_reset();
        @(negedge clk);
        a_push = 1'b1; a_data = 4'hA;
        @(negedge clk);
        a_push = 1'b0; b_pop = 1'b1;
        #1;
        n_cmp++;
        if ({b_gnt, popenbl, tos} !== {2'b11, 3'd1}) begin
            n_bad++; $display("FAIL b2b_pop: got b=%b pop=%b tos=%0d", b_gnt, popenbl, tos);
        end
        @(negedge clk);
        b_pop = 1'b0;
        #1;
        n_cmp++;
        if ({rd_valid, rd_id, popdataout, stack_empty} !== {2'b11, 4'hA, 1'b1}) begin
            n_bad++; $display("FAIL b2b_data: got v=%b id=%b d=%h e=%b want 1/1/a/1", rd_valid, rd_id, popdataout, stack_empty);
        end
    endtask

    task automatic test_reset_mid;
        do_reset();
        @(negedge clk);
        a_push = 1'b1; a_data = 4'h1;
        @(negedge clk);
        a_data = 4'h2;
        @(negedge clk);
        a_push = 1'b0; a_pop = 1'b1;
        #1;
        n_cmp++;
        if ({popenbl, tos} !== {1'b1, 3'd2}) begin
            n_bad++; $display("FAIL rstmid_pop: got pop=%b tos=%0d want 1/2", popenbl, tos);
        end
        @(negedge clk);
        a_pop = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if ({rd_valid, tos, stack_empty, stack_full} !== {1'b0, 3'd0, 1'b1, 1'b0}) begin
            n_bad++; $display("FAIL rstmid_state: got v=%b tos=%0d e=%b f=%b want 0/0/1/0", rd_valid, tos, stack_empty, stack_full);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_push_fill();
        test_pop_drain();
        test_round_robin();
        test_underflow();
        test_full_contention();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stack_arb_ctrl.md
Name: stack_arb_ctrl

Overview:
- Sequencing and arbitration controller for the 8-entry x 4-bit stack memory.
- Accepts push/pop requests from two requesters (A, B) and grants at most one operation per cycle.
- Owns the top-of-stack pointer and the full/empty state.
- Drives the memory's push/pop enables, tos and stack_full inputs, and tags returning pop data with the requester ID.

Parameters:
DEPTH, 8, number of stack entries; must equal 2**AW
AW, 3, width of tos pointer
DW, 4, data width (pass-through to memory)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
a_push  in  1  requester A push request
a_pop  in  1  requester A pop request
a_data  in  DW  requester A push data
b_push  in  1  requester B push request
b_pop  in  1  requester B pop request
b_data  in  DW  requester B push data
a_gnt  out  1  A's request accepted this cycle (combinational)
b_gnt  out  1  B's request accepted this cycle (combinational)
pushenbl  out  1  to memory: write pushdatain at tos
popenbl  out  1  to memory: read pop address into popdataout
tos  out  AW  to memory: top-of-stack pointer (registered)
stack_full  out  1  registered, count==DEPTH
stack_empty  out  1  registered, count==0
pushdatain  out  DW  muxed push data of granted requester
rd_valid  out  1  registered; popdataout valid this cycle
rd_id  out  1  registered; 0=A, 1=B owner of rd_valid data
ovf_err  out  1  sticky: push requested while full
unf_err  out  1  sticky: pop requested while empty

Behaviour:
- Reset (rst_n=0 at edge):
  - tos=0, count=0, stack_full=0, stack_empty=1.
  - rd_valid=0, rd_id=0, ovf_err=0, unf_err=0.
  - Round-robin pointer = A.
  - Combinational outputs follow from the reset state.
- Reset asserted mid-operation discards in-flight pop; rd_valid=0 next cycle.
- Per-requester request legality:
  - push&pop both high from one requester = illegal; treat as no request; set both sticky error flags.
- Eligibility:
  - Push eligible only if !stack_full.
  - Pop eligible only if !stack_empty.
  - An ineligible request is not granted and sets ovf_err/unf_err; it never reaches the memory.
- Arbitration:
  - Among eligible requesters, one grant per cycle.
  - Round-robin: after granting X, the other requester has priority next contention cycle.
  - A sole eligible requester is granted regardless of the pointer.
  - Requester holds its request until granted; no queueing inside the block.
- Memory drive (same cycle as grant):
  - pushenbl=grant&push; popenbl=grant&pop; pushdatain=granted requester's data (a_data when idle).
- Pointer/count update at edge of granted op:
  - Push, count<DEPTH-1: tos<=tos+1, count+1.
  - Push, count==DEPTH-1: tos unchanged (stays DEPTH-1), count=DEPTH, stack_full<=1.
  - Pop while full: tos unchanged, count=DEPTH-1, stack_full<=0.
  - Pop, not full: tos<=tos-1, count-1; stack_empty<=1 when count becomes 0.
  - count is internal, AW+1 bits; tos never wraps.
- Pop latency: pop granted in cycle N gives popdataout valid in cycle N+1, with rd_valid=1 and rd_id=granted ID for exactly one cycle.
- Back-to-back pops allowed every cycle.
- Push then pop in consecutive cycles returns the just-pushed data.
- Sticky errors clear only on reset.

Optional Feature:
- Macro: STACK_ARB_CTRL_ERRCNT_EN.
- When defined:
  - Adds output err_cnt (8 bits).
  - Increments once per cycle in which any ovf/unf condition occurs.
  - Saturates at 255; reset to 0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then A pushes 1,2,…,8 on consecutive cycles -> tos 0..7 then held at 7; stack_full=1 after 8th push; stack_empty=0.
- Full stack, B pops 8 times -> rd_id=1, data 8,7,…,1 each one cycle after grant; tos stays 7 on first pop, then 6..0; stack_empty=1 at end.
- Empty stack, A and B both push each cycle (data 3 and 5) for 4 cycles -> grants alternate A,B,A,B; later pops return 5,3,5,3.
- Empty stack, A pops -> no a_gnt, popenbl=0, unf_err=1 and sticky; with ERRCNT_EN, err_cnt=1.
- Full stack, B pushes 0xF while A pops -> only A granted; ovf_err=1; data read = last pushed; stack_full clears.
- Reset asserted the cycle after a pop grant -> rd_valid=0, tos=0, stack_empty=1 on following cycle.
